// File: rtl/params_pkg.sv
// Shared types and constants for the dtcore32 AXI4-Lite MEM-stage initiator.
package params_pkg;

    // Transaction sequencer states of the AXI4-Lite initiator
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        DONE_RD = 3'd5,
        DONE_WR = 3'd6
    } axil_state_t;

    // AXI response encodings used by the initiator
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Any response other than OKAY (SLVERR, DECERR, EXOKAY) is an error for a lite access
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != AXI_RESP_OKAY);
    endfunction

endpackage : params_pkg

// File: rtl/axil_master.sv
// AXI4-Lite initiator for the dtcore32 MEM stage: one load or store at a time,
// completion reported with single-cycle done pulses that release the stall.
module axil_master
    import params_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      CLK,
    input  logic                      RST,

    input  logic                      AXIL_EN,
    input  logic                      AXIL_WE,
    input  logic [ADDR_WIDTH-1:0]     AXIL_ADDR,
    input  logic [DATA_WIDTH-1:0]     AXIL_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   AXIL_WSTRB,
    output logic                      AXIL_DONE_READ,
    output logic                      AXIL_DONE_WRITE,
    output logic [DATA_WIDTH-1:0]     AXIL_RDATA,
    output logic                      AXIL_ERR,

    output logic                      M_ARVALID,
    input  logic                      M_ARREADY,
    output logic [ADDR_WIDTH-1:0]     M_ARADDR,
    output logic [2:0]                M_ARPROT,
    input  logic                      M_RVALID,
    output logic                      M_RREADY,
    input  logic [DATA_WIDTH-1:0]     M_RDATA,
    input  logic [1:0]                M_RRESP,

    output logic                      M_AWVALID,
    input  logic                      M_AWREADY,
    output logic [ADDR_WIDTH-1:0]     M_AWADDR,
    output logic [2:0]                M_AWPROT,
    output logic                      M_WVALID,
    input  logic                      M_WREADY,
    output logic [DATA_WIDTH-1:0]     M_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_WSTRB,
    input  logic                      M_BVALID,
    output logic                      M_BREADY,
    input  logic [1:0]                M_BRESP
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // Sequencer and request-holding registers
    axil_state_t             state_q,    state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,    wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q,    wstrb_d;
    logic [DATA_WIDTH-1:0]   rdata_q,    rdata_d;
    logic                    err_flag_q, err_flag_d;
    logic                    aw_acc_q,   aw_acc_d;
    logic                    w_acc_q,    w_acc_d;

    // Registered handshake and status outputs
    logic                    arvalid_q,  arvalid_d;
    logic                    rready_q,   rready_d;
    logic                    awvalid_q,  awvalid_d;
    logic                    wvalid_q,   wvalid_d;
    logic                    bready_q,   bready_d;
    logic                    done_rd_q,  done_rd_d;
    logic                    done_wr_q,  done_wr_d;
    logic                    err_q,      err_d;

    // Next-state logic: request capture in IDLE, channel handshakes elsewhere
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        err_flag_d = err_flag_q;
        aw_acc_d   = aw_acc_q;
        w_acc_d    = w_acc_q;

        case (state_q)
            IDLE: begin
                // The request fields are only looked at here, so a stalled
                // pipeline can keep them on the bus without re-issuing.
                if (AXIL_EN) begin
                    addr_d     = AXIL_ADDR;
                    err_flag_d = 1'b0;
                    if (AXIL_WE) begin
                        wdata_d  = AXIL_WDATA;
                        wstrb_d  = AXIL_WSTRB;
                        aw_acc_d = 1'b0;
                        w_acc_d  = 1'b0;
                        state_d  = WR_REQ;
                    end else begin
                        state_d  = RD_ADDR;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            RD_ADDR: begin
                if (arvalid_q && M_ARREADY) begin
                    state_d = RD_DATA;
                end else begin
                    state_d = RD_ADDR;
                end
            end

            RD_DATA: begin
                if (rready_q && M_RVALID) begin
                    rdata_d    = M_RDATA;
                    err_flag_d = resp_is_err(M_RRESP);
                    state_d    = DONE_RD;
                end else begin
                    state_d = RD_DATA;
                end
            end

            WR_REQ: begin
                // AW and W complete independently; leave once both have been taken.
                aw_acc_d = aw_acc_q | (awvalid_q & M_AWREADY);
                w_acc_d  = w_acc_q  | (wvalid_q  & M_WREADY);
                if (aw_acc_d && w_acc_d) begin
                    state_d = WR_RESP;
                end else begin
                    state_d = WR_REQ;
                end
            end

            WR_RESP: begin
                if (bready_q && M_BVALID) begin
                    err_flag_d = resp_is_err(M_BRESP);
                    state_d    = DONE_WR;
                end else begin
                    state_d = WR_RESP;
                end
            end

            DONE_RD: begin
                state_d = IDLE;
            end

            DONE_WR: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output next values decoded from the next state so every output comes straight from a flop
    always_comb begin
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        done_rd_d = 1'b0;
        done_wr_d = 1'b0;
        err_d     = 1'b0;

        case (state_d)
            RD_ADDR: arvalid_d = 1'b1;
            RD_DATA: rready_d  = 1'b1;
            WR_REQ: begin
                awvalid_d = ~aw_acc_d;
                wvalid_d  = ~w_acc_d;
            end
            WR_RESP: bready_d = 1'b1;
            DONE_RD: begin
                done_rd_d = 1'b1;
                err_d     = err_flag_d;
            end
            DONE_WR: begin
                done_wr_d = 1'b1;
                err_d     = err_flag_d;
            end
            default: begin
                arvalid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset; a reset mid-transaction simply abandons it
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            addr_q     <= {ADDR_WIDTH{1'b0}};
            wdata_q    <= {DATA_WIDTH{1'b0}};
            wstrb_q    <= {STRB_WIDTH{1'b0}};
            rdata_q    <= {DATA_WIDTH{1'b0}};
            err_flag_q <= 1'b0;
            aw_acc_q   <= 1'b0;
            w_acc_q    <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            done_rd_q  <= 1'b0;
            done_wr_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            err_flag_q <= err_flag_d;
            aw_acc_q   <= aw_acc_d;
            w_acc_q    <= w_acc_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            done_rd_q  <= done_rd_d;
            done_wr_q  <= done_wr_d;
            err_q      <= err_d;
        end
    end

    // Address, data and strobes come from the request registers, which only change in IDLE
    assign M_ARVALID       = arvalid_q;
    assign M_ARADDR        = addr_q;
    assign M_ARPROT        = 3'b000;
    assign M_RREADY        = rready_q;
    assign M_AWVALID       = awvalid_q;
    assign M_AWADDR        = addr_q;
    assign M_AWPROT        = 3'b000;
    assign M_WVALID        = wvalid_q;
    assign M_WDATA         = wdata_q;
    assign M_WSTRB         = wstrb_q;
    assign M_BREADY        = bready_q;
    assign AXIL_DONE_READ  = done_rd_q;
    assign AXIL_DONE_WRITE = done_wr_q;
    assign AXIL_RDATA      = rdata_q;
    assign AXIL_ERR        = err_q;

endmodule : axil_master

// File: tb/tb_axil_master.sv
// Self-checking bench for axil_master: delay-programmable slave, table vectors,
// hand-written corner sequences and randomized traffic against a memory model.
module tb_axil_master;

    logic        CLK = 1'b0;
    logic        RST;
    logic        AXIL_EN, AXIL_WE;
    logic [31:0] AXIL_ADDR, AXIL_WDATA;
    logic [3:0]  AXIL_WSTRB;
    logic        AXIL_DONE_READ, AXIL_DONE_WRITE, AXIL_ERR;
    logic [31:0] AXIL_RDATA;
    logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
    logic [31:0] M_ARADDR, M_RDATA;
    logic [2:0]  M_ARPROT, M_AWPROT;
    logic [1:0]  M_RRESP, M_BRESP;
    logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
    logic [31:0] M_AWADDR, M_WDATA;
    logic [3:0]  M_WSTRB;

    always #5 CLK = ~CLK;

    axil_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .CLK(CLK), .RST(RST),
        .AXIL_EN(AXIL_EN), .AXIL_WE(AXIL_WE), .AXIL_ADDR(AXIL_ADDR),
        .AXIL_WDATA(AXIL_WDATA), .AXIL_WSTRB(AXIL_WSTRB),
        .AXIL_DONE_READ(AXIL_DONE_READ), .AXIL_DONE_WRITE(AXIL_DONE_WRITE),
        .AXIL_RDATA(AXIL_RDATA), .AXIL_ERR(AXIL_ERR),
        .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR), .M_ARPROT(M_ARPROT),
        .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP),
        .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY), .M_AWADDR(M_AWADDR), .M_AWPROT(M_AWPROT),
        .M_WVALID(M_WVALID), .M_WREADY(M_WREADY), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB),
        .M_BVALID(M_BVALID), .M_BREADY(M_BREADY), .M_BRESP(M_BRESP)
    );

    // ---------------- slave model (programmable delays, 16-word memory) ----------------
    int          cfg_ar, cfg_r, cfg_aw, cfg_w, cfg_b;
    logic [1:0]  cfg_resp;
    logic        mem_init;
    int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic        r_pend, aw_got, w_got;
    logic [31:0] r_addr, aw_addr_s, w_data_s;
    logic [3:0]  w_strb_s;
    logic [31:0] smem [16];

    function automatic logic [31:0] init_word(input int i);
        if (i == 0)      return 32'hDEAD_BEEF;
        else if (i == 1) return 32'hAAAA_AAAA;
        else             return 32'h5A00_0000 | 32'(i);
    endfunction

    assign M_ARREADY = M_ARVALID && (ar_cnt == cfg_ar);
    assign M_RVALID  = r_pend && (r_cnt == cfg_r);
    assign M_RDATA   = smem[r_addr[5:2]];
    assign M_RRESP   = cfg_resp;
    assign M_AWREADY = M_AWVALID && (aw_cnt == cfg_aw);
    assign M_WREADY  = M_WVALID && (w_cnt == cfg_w);
    assign M_BVALID  = aw_got && w_got && (b_cnt == cfg_b);
    assign M_BRESP   = cfg_resp;

    always @(posedge CLK) begin
        if (RST) begin
            ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            r_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            r_addr <= 32'h0; aw_addr_s <= 32'h0; w_data_s <= 32'h0; w_strb_s <= 4'h0;
            if (mem_init) for (int i = 0; i < 16; i++) smem[i] <= init_word(i);
        end else begin
            ar_cnt <= (M_ARVALID && !M_ARREADY) ? ar_cnt + 1 : 0;
            if (M_ARVALID && M_ARREADY) begin
                r_pend <= 1'b1; r_cnt <= 0; r_addr <= M_ARADDR;
            end else if (M_RVALID && M_RREADY) begin
                r_pend <= 1'b0;
            end else if (r_pend && !M_RVALID) begin
                r_cnt <= r_cnt + 1;
            end
            aw_cnt <= (M_AWVALID && !M_AWREADY) ? aw_cnt + 1 : 0;
            w_cnt  <= (M_WVALID && !M_WREADY) ? w_cnt + 1 : 0;
            if (M_AWVALID && M_AWREADY) begin aw_got <= 1'b1; aw_addr_s <= M_AWADDR; end
            if (M_WVALID && M_WREADY) begin w_got <= 1'b1; w_data_s <= M_WDATA; w_strb_s <= M_WSTRB; end
            if (M_BVALID && M_BREADY) begin
                aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
                for (int k = 0; k < 4; k++)
                    if (w_strb_s[k]) smem[aw_addr_s[5:2]][8*k +: 8] <= w_data_s[8*k +: 8];
            end else if (aw_got && w_got && !M_BVALID) begin
                b_cnt <= b_cnt + 1;
            end
        end
    end

    // ---------------- bus monitor (sampled at negedge) ----------------
    int ar_hs = 0, aw_hs = 0, w_hs = 0, aw_hi = 0, w_hi = 0, done_cnt = 0;
    int width_err = 0, stab_err = 0;
    logic [31:0] ar_log [$];
    logic        pv_done = 1'b0, pv_rst = 1'b1;
    logic        pv_arv = 1'b0, pv_arr = 1'b0, pv_awv = 1'b0, pv_awr = 1'b0, pv_wv = 1'b0, pv_wr = 1'b0;
    logic [31:0] pv_araddr = 32'h0, pv_awaddr = 32'h0, pv_wdata = 32'h0;
    logic [3:0]  pv_wstrb = 4'h0;

    always @(negedge CLK) begin
        if (M_ARVALID && M_ARREADY) begin ar_hs <= ar_hs + 1; ar_log.push_back(M_ARADDR); end
        if (M_AWVALID && M_AWREADY) aw_hs <= aw_hs + 1;
        if (M_WVALID && M_WREADY)   w_hs  <= w_hs + 1;
        if (M_AWVALID) aw_hi <= aw_hi + 1;
        if (M_WVALID)  w_hi  <= w_hi + 1;
        if (AXIL_DONE_READ || AXIL_DONE_WRITE) done_cnt <= done_cnt + 1;
        if (((AXIL_DONE_READ || AXIL_DONE_WRITE) && pv_done) ||
            (AXIL_ERR && !(AXIL_DONE_READ || AXIL_DONE_WRITE)) ||
            (AXIL_DONE_READ && AXIL_DONE_WRITE))
            width_err <= width_err + 1;
        if (!RST && !pv_rst) begin
            if ((pv_arv && !pv_arr && (!M_ARVALID || M_ARADDR != pv_araddr)) ||
                (pv_awv && !pv_awr && (!M_AWVALID || M_AWADDR != pv_awaddr)) ||
                (pv_wv && !pv_wr && (!M_WVALID || M_WDATA != pv_wdata || M_WSTRB != pv_wstrb)))
                stab_err <= stab_err + 1;
        end
        pv_done <= AXIL_DONE_READ || AXIL_DONE_WRITE;
        pv_rst <= RST;
        pv_arv <= M_ARVALID; pv_arr <= M_ARREADY; pv_araddr <= M_ARADDR;
        pv_awv <= M_AWVALID; pv_awr <= M_AWREADY; pv_awaddr <= M_AWADDR;
        pv_wv <= M_WVALID; pv_wr <= M_WREADY; pv_wdata <= M_WDATA; pv_wstrb <= M_WSTRB;
    end

    // ---------------- checking infrastructure and reference model ----------------
    int n_pass = 0, n_total = 0;
    logic [31:0] model_mem [16];
    logic [31:0] model_rdata;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          ar, r, aw, w, b;
        logic [1:0]  resp;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    task automatic run_txn(input vec_t v, input bit chained, input string tag);
        int ar0, aw0, w0, awh0, wh0, d0, lat, idx, exp_lat;
        bit got;
        ar0 = ar_hs; aw0 = aw_hs; w0 = w_hs; awh0 = aw_hi; wh0 = w_hi; d0 = done_cnt;
        cfg_ar = v.ar; cfg_r = v.r; cfg_aw = v.aw; cfg_w = v.w; cfg_b = v.b; cfg_resp = v.resp;
        AXIL_EN = 1'b1; AXIL_WE = v.we; AXIL_ADDR = v.addr;
        AXIL_WDATA = v.wdata; AXIL_WSTRB = v.wstrb;
        exp_lat = v.exp_lat + (chained ? 1 : 0);
        lat = 0; got = 1'b0;
        while (!got && lat < 400) begin
            @(negedge CLK);
            lat++;
            if (AXIL_DONE_READ || AXIL_DONE_WRITE) got = 1'b1;
        end
        chk({tag, "/done_seen"}, 64'(got), 64'd1);
        chk({tag, "/done_kind"}, {62'd0, AXIL_DONE_READ, AXIL_DONE_WRITE}, v.we ? 64'd1 : 64'd2);
        chk({tag, "/latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "/err"}, 64'(AXIL_ERR), 64'(v.exp_err));
        chk({tag, "/rdata"}, 64'(AXIL_RDATA), 64'(v.exp_rdata));
        #1;
        chk({tag, "/handshakes"}, 64'({8'(ar_hs - ar0), 8'(aw_hs - aw0), 8'(w_hs - w0)}),
            v.we ? 64'h00_01_01 : 64'h01_00_00);
        if (v.we)
            chk({tag, "/valid_cycles"}, 64'({16'(aw_hi - awh0), 16'(w_hi - wh0)}),
                64'({16'(v.aw + 1), 16'(v.w + 1)}));
        chk({tag, "/done_count"}, 64'(done_cnt - d0), 64'd1);
        idx = int'(v.addr[5:2]);
        if (v.we) begin
            for (int k = 0; k < 4; k++)
                if (v.wstrb[k]) model_mem[idx][8*k +: 8] = v.wdata[8*k +: 8];
        end else begin
            model_rdata = model_mem[idx];
        end
    endtask

    vec_t vt [8];
    vec_t rv;

    initial begin
        int k, ridx, n0;
        bit got, chained;
        RST = 1'b1; mem_init = 1'b1;
        AXIL_EN = 1'b0; AXIL_WE = 1'b0; AXIL_ADDR = 32'h0; AXIL_WDATA = 32'h0; AXIL_WSTRB = 4'h0;
        cfg_ar = 0; cfg_r = 0; cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_resp = 2'b00;
        for (int i = 0; i < 16; i++) model_mem[i] = init_word(i);
        model_rdata = 32'h0;

        //          we    addr          wdata         strb  ar r  aw w  b  resp   exp_rdata     err   lat
        vt[0] = '{1'b0, 32'h4000_0000, 32'h0,        4'h0, 0, 0,  0, 0, 0, 2'b00, 32'hDEAD_BEEF, 1'b0, 3};
        vt[1] = '{1'b1, 32'h4000_0004, 32'h1234_5678, 4'h3, 0, 0,  3, 0, 0, 2'b00, 32'hDEAD_BEEF, 1'b0, 6};
        vt[2] = '{1'b0, 32'h4000_0004, 32'h0,        4'h0, 0, 0,  0, 0, 0, 2'b00, 32'hAAAA_5678, 1'b0, 3};
        vt[3] = '{1'b1, 32'h4000_0008, 32'hCAFE_F00D, 4'hF, 0, 0,  0, 0, 0, 2'b10, 32'hAAAA_5678, 1'b1, 3};
        vt[4] = '{1'b0, 32'h4000_0008, 32'h0,        4'h0, 0, 10, 0, 0, 0, 2'b00, 32'hCAFE_F00D, 1'b0, 13};
        vt[5] = '{1'b0, 32'h4000_000C, 32'h0,        4'h0, 1, 2,  0, 0, 0, 2'b10, 32'h5A00_0003, 1'b1, 6};
        vt[6] = '{1'b1, 32'h4000_0010, 32'hFFFF_0000, 4'hC, 0, 0,  0, 2, 1, 2'b00, 32'h5A00_0003, 1'b0, 6};
        vt[7] = '{1'b0, 32'h4000_0010, 32'h0,        4'h0, 2, 0,  0, 0, 0, 2'b00, 32'hFFFF_0004, 1'b0, 5};

        repeat (3) @(negedge CLK);
        chk("rst_ctrl", {56'd0, M_ARVALID, M_AWVALID, M_WVALID, M_RREADY, M_BREADY,
                         AXIL_DONE_READ, AXIL_DONE_WRITE, AXIL_ERR}, 64'd0);
        chk("rst_rdata", 64'(AXIL_RDATA), 64'd0);
        chk("rst_addr", {M_ARADDR, M_AWADDR}, 64'd0);
        chk("rst_wdata", {22'd0, M_WDATA, M_WSTRB, M_ARPROT, M_AWPROT}, 64'd0);
        RST = 1'b0; mem_init = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 8; i++) begin
            run_txn(vt[i], 1'b0, $sformatf("vec%0d", i));
            AXIL_EN = 1'b0;
            @(negedge CLK);
        end

        // Back-to-back: EN stays high with a new address right after the done cycle
        rv = '{1'b0, 32'h4000_0000, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, model_mem[0], 1'b0, 3};
        run_txn(rv, 1'b0, "b2b_first");
        rv = '{1'b0, 32'h0000_0008, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, model_mem[2], 1'b0, 3};
        run_txn(rv, 1'b1, "b2b_second");
        n0 = ar_log.size();
        chk("b2b_ar_addrs", {ar_log[n0-2], ar_log[n0-1]}, {32'h4000_0000, 32'h0000_0008});
        AXIL_EN = 1'b0;
        @(negedge CLK);

        // Reset while waiting in the read-data phase
        cfg_ar = 0; cfg_r = 5; cfg_resp = 2'b00;
        AXIL_EN = 1'b1; AXIL_WE = 1'b0; AXIL_ADDR = 32'h4000_000C;
        got = 1'b0; k = 0;
        while (!got && k < 20) begin
            @(negedge CLK);
            k++;
            if (M_RREADY) got = 1'b1;
        end
        chk("midrst_rready_seen", 64'(got), 64'd1);
        n0 = done_cnt;
        RST = 1'b1; AXIL_EN = 1'b0;
        @(negedge CLK);
        chk("midrst_ctrl", {56'd0, M_ARVALID, M_AWVALID, M_WVALID, M_RREADY, M_BREADY,
                            AXIL_DONE_READ, AXIL_DONE_WRITE, AXIL_ERR}, 64'd0);
        chk("midrst_rdata", 64'(AXIL_RDATA), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("midrst_no_done", 64'(done_cnt - n0), 64'd0);
        model_rdata = 32'h0;
        rv = '{1'b0, 32'h4000_0000, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, model_mem[0], 1'b0, 3};
        run_txn(rv, 1'b0, "after_rst");
        AXIL_EN = 1'b0;
        @(negedge CLK);

        // Randomized traffic against the memory model
        for (int n = 0; n < 40; n++) begin
            ridx = $urandom_range(0, 15);
            rv.we = 1'($urandom_range(0, 1));
            rv.addr = 32'h4000_0000 | (32'(ridx) << 2);
            rv.wdata = $urandom;
            rv.wstrb = 4'($urandom_range(0, 15));
            rv.ar = $urandom_range(0, 4); rv.r = $urandom_range(0, 4);
            rv.aw = $urandom_range(0, 4); rv.w = $urandom_range(0, 4); rv.b = $urandom_range(0, 4);
            rv.resp = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
            rv.exp_err = (rv.resp != 2'b00);
            rv.exp_rdata = rv.we ? model_rdata : model_mem[ridx];
            rv.exp_lat = rv.we ? 3 + ((rv.aw > rv.w) ? rv.aw : rv.w) + rv.b : 3 + rv.ar + rv.r;
            chained = (n > 0) && ($urandom_range(0, 1) == 1);
            if (!chained) begin
                AXIL_EN = 1'b0;
                @(negedge CLK);
            end
            run_txn(rv, chained, $sformatf("rnd%0d", n));
        end
        AXIL_EN = 1'b0;
        repeat (3) @(negedge CLK);

        chk("pulse_shape", 64'(width_err), 64'd0);
        chk("valid_stability", 64'(stab_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_axil_master
